// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs decoded R/I/J fields into 32-bit words for instruction memory
// Optional illegal-tuple screening via INSTR_ENCODER_CHECK_EN.
module instr_encoder #(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    fmt,
  input  logic [5:0]    opcode,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [4:0]    rd,
  input  logic [4:0]    shmt,
  input  logic [5:0]    funct,
  input  logic [15:0]   imm,
  input  logic [25:0]   target,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   instr,
  output logic [AW-1:0] mem_addr,
  output logic          done,
  output logic          err
);

  localparam int IW = $clog2(DEPTH + 1);

  typedef enum logic {S_LOAD, S_FULL} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic            r_done;
  logic [31:0]     r_word [2];
  logic [AW-1:0]   r_addr [2];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_count;

  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_packed;
  logic [AW-1:0]   w_addr;

  // in_ready looks only at registered occupancy, never at out_ready
  assign in_ready = rst_n && !clr && !r_done && (r_count < 2'd2);
  assign w_accept = in_valid && in_ready;
  assign w_pop    = (r_count != 2'd0) && out_ready && !clr;
  assign w_addr   = AW'(r_idx) << 2;

  always_comb begin
    w_packed = '0;
    case (fmt)
      2'd0:    w_packed = {opcode, rs1, rs2, rd, shmt, funct};
      2'd1:    w_packed = {opcode, rs1, rs2, imm};
      default: w_packed = {opcode, target};
    endcase
  end

`ifdef INSTR_ENCODER_CHECK_EN
  logic w_illegal;
  logic r_err;

  assign w_illegal = (fmt == 2'd3) || ((fmt == 2'd0) && (opcode != 6'd0));
  assign w_push    = w_accept && !w_illegal;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_err <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_push = w_accept;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_state <= S_LOAD;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_push) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == IW'(DEPTH - 1)) begin
              r_state <= S_FULL;
              r_done  <= 1'b1;
            end
          end
        end
        S_FULL: begin
          r_done <= 1'b1;
        end
        default: begin
          r_state <= S_LOAD;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign done = r_done;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_word[i] <= '0;
        r_addr[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_word[r_wr_ptr] <= w_packed;
        r_addr[r_wr_ptr] <= w_addr;
        r_wr_ptr         <= !r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= !r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid = (r_count != 2'd0);
  assign instr     = r_word[r_rd_ptr];
  assign mem_addr  = r_addr[r_rd_ptr];

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder (DEPTH=4)
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_ready, out_valid, out_ready, done, err;
  logic [1:0]  fmt;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs1, rs2, rd, shmt;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] instr, mem_addr;

  instr_encoder #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .shmt(shmt),
    .funct(funct), .imm(imm), .target(target), .out_valid(out_valid),
    .out_ready(out_ready), .instr(instr), .mem_addr(mem_addr), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  logic [63:0] sb[$];
  int          pop_cyc[$];
  logic [31:0] exp_word;
  bit          exp_push;
  int          exp_idx  = 0;
  bit          hold_pending = 0;
  logic [31:0] hold_instr, hold_addr;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Accept tracker: records the expected word for each handshake
  always @(negedge clk) begin
    if (in_valid && in_ready && exp_push) begin
      sb.push_back({exp_word, 32'(exp_idx * 4)});
      exp_idx++;
    end
  end

  // Output monitor: compares popped words and stability under backpressure
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n && !clr && out_valid) begin
      if (hold_pending) begin
        chk("hold_instr", instr, hold_instr);
        chk("hold_addr", mem_addr, hold_addr);
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_word: got %h at %h expected none", instr, mem_addr);
        end else begin
          e = sb.pop_front();
          chk("word", instr, e[63:32]);
          chk("addr", mem_addr, e[31:0]);
        end
        pop_cyc.push_back(cyc);
      end
    end
    hold_pending = rst_n && !clr && out_valid && !out_ready;
    hold_instr   = instr;
    hold_addr    = mem_addr;
  end

  task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] d, input logic [4:0] s,
                      input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg,
                      input logic [31:0] expw, input bit push, input int maxw,
                      output bit acc, output int waited);
    fmt = f; opcode = op; rs1 = a; rs2 = b; rd = d; shmt = s; funct = fn;
    imm = im; target = tg; exp_word = expw; exp_push = push;
    in_valid = 1'b1;
    acc = 0;
    waited = 0;
    while (!acc && waited < maxw) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      else waited++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    sb.delete();
    exp_idx = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((out_valid || sb.size() != 0) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_valid", out_valid, 0);
    chk("drain_sb", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    int w;
    rst_n = 0; clr = 0; in_valid = 0; out_ready = 1;
    fmt = 0; opcode = 0; rs1 = 0; rs2 = 0; rd = 0; shmt = 0; funct = 0; imm = 0; target = 0;
    exp_word = 0; exp_push = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 1);

    // R-type with one-cycle latency
    send(0, 0, 10, 11, 9, 0, 6'h20, 0, 0, 32'h014B4820, 1, 4, acc, w);
    chk("r_acc", acc, 1);
    chk("r_latency", out_valid, 1);
    wait_drain();

    // I then J back to back
    do_clr();
    pop_cyc.delete();
    send(1, 6'h08, 9, 8, 0, 0, 0, 16'd5, 0, 32'h21280005, 1, 4, acc, w);
    send(2, 6'h02, 0, 0, 0, 0, 0, 0, 26'h100, 32'h08000100, 1, 4, acc, w);
    wait_drain();
    chk("ij_pops", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2) chk("ij_consecutive", pop_cyc[1] - pop_cyc[0], 1);

    // Backpressure: two buffered, third waits
    do_clr();
    out_ready = 0;
    send(2, 6'h03, 0, 0, 0, 0, 0, 0, 26'd1, 32'h0C000001, 1, 4, acc, w);
    send(2, 6'h03, 0, 0, 0, 0, 0, 0, 26'd2, 32'h0C000002, 1, 4, acc, w);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head", instr, 32'h0C000001);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join_none
    send(2, 6'h03, 0, 0, 0, 0, 0, 0, 26'd3, 32'h0C000003, 1, 10, acc, w);
    chk("bp_third_acc", acc, 1);
    chk("bp_third_waited", (w >= 3), 1);
    wait_drain();

    // Fill to DEPTH
    do_clr();
    for (int i = 0; i < 4; i++)
      send(1, 6'h23, 1, 2, 0, 0, 0, 16'h0010 + 16'(i), 0, 32'h8C220010 + 32'(i), 1, 4, acc, w);
    chk("full_done", done, 1);
    chk("full_in_ready", in_ready, 0);
    send(1, 6'h23, 1, 2, 0, 0, 0, 16'h0099, 0, 32'h8C220099, 1, 3, acc, w);
    chk("full_reject", acc, 0);
    wait_drain();
    chk("full_done_hold", done, 1);
    do_clr();
    chk("clr_done", done, 0);
    send(0, 0, 10, 11, 9, 0, 6'h20, 0, 0, 32'h014B4820, 1, 4, acc, w);
    wait_drain();

    // Mid-stream clr and reset
    do_clr();
    out_ready = 0;
    send(2, 6'h03, 0, 0, 0, 0, 0, 0, 26'd1, 32'h0C000001, 1, 4, acc, w);
    send(2, 6'h03, 0, 0, 0, 0, 0, 0, 26'd2, 32'h0C000002, 1, 4, acc, w);
    chk("pre_clr_valid", out_valid, 1);
    do_clr();
    chk("clr_flush_valid", out_valid, 0);
    send(2, 6'h03, 0, 0, 0, 0, 0, 0, 26'd1, 32'h0C000001, 1, 4, acc, w);
    send(2, 6'h03, 0, 0, 0, 0, 0, 0, 26'd2, 32'h0C000002, 1, 4, acc, w);
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("rst_flush_valid", out_valid, 0);
    chk("rst_flush_instr", instr, 0);
    chk("rst_flush_ready", in_ready, 0);
    rst_n = 1;
    sb.delete();
    exp_idx = 0;
    out_ready = 1;

    // clr coincident with in_valid
    fmt = 0; opcode = 0; rs1 = 10; rs2 = 11; rd = 9; shmt = 0; funct = 6'h20;
    exp_word = 32'h014B4820; exp_push = 1;
    in_valid = 1; clr = 1;
    @(negedge clk);
    chk("clr_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    in_valid = 0; clr = 0;
    chk("clr_no_accept", out_valid, 0);

`ifdef INSTR_ENCODER_CHECK_EN
    send(3, 6'h02, 0, 0, 0, 0, 0, 0, 26'h3FFFFFF, 32'h0BFFFFFF, 0, 4, acc, w);
    chk("ill_acc", acc, 1);
    chk("ill_err", err, 1);
    chk("ill_no_valid", out_valid, 0);
    send(0, 0, 10, 11, 9, 0, 6'h20, 0, 0, 32'h014B4820, 1, 4, acc, w);
    wait_drain();
    chk("err_sticky", err, 1);
    send(0, 6'h01, 0, 0, 0, 0, 6'h2A, 0, 0, 32'h0400002A, 0, 4, acc, w);
    chk("ill_r_no_valid", out_valid, 0);
    do_clr();
    chk("clr_err", err, 0);
`else
    send(3, 6'h02, 0, 0, 0, 0, 0, 0, 26'h3FFFFFF, 32'h0BFFFFFF, 1, 4, acc, w);
    send(0, 6'h01, 0, 0, 0, 0, 6'h2A, 0, 0, 32'h0400002A, 1, 4, acc, w);
    wait_drain();
    chk("noerr", err, 0);
`endif

    chk("sb_final", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
